receiver_input_buffer: RTL and testbench
========================================

# receiver_input_buffer

- Parametrised successor to the single-pair receiver front end.
- Captures NUM_CH channels of I/Q samples on a one-cycle sample strobe in the dsp_clk domain.
- Serialises each captured set into a word-wide memory write stream addressed over a circular buffer region.
- Adds an I-only mode, a wrap indication and sticky overflow detection; sits between the ADC capture logic and the DSP sample RAM.

## Interface

Parameters:
- DATA_W, 16, sample width per I or Q word
- ADDR_W, 16, write address width
- NUM_CH, 1, number of I/Q channel pairs (1..8)
- BASE_ADDR, 0, first address of the circular buffer
- DEPTH, 1024, buffer length in words; require DEPTH >= 2*NUM_CH and BASE_ADDR+DEPTH <= 2^ADDR_W

Ports:
- dsp_clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- enable  in  1  accept new sample sets when high
- mode  in  1  0 = write I then Q per channel, 1 = write I only
- sample_valid  in  1  one-cycle strobe, inputs valid this cycle
- inphase_input  in  NUM_CH*DATA_W  I samples, channel 0 in LSBs
- quad_input  in  NUM_CH*DATA_W  Q samples, channel 0 in LSBs
- clr_overflow  in  1  clears overflow flag
- write_data  out  DATA_W  memory write data
- write_addr  out  ADDR_W  memory write address
- write_en_out  out  1  write strobe, one word per high cycle
- buf_wrap  out  1  one-cycle pulse with the write to BASE_ADDR+DEPTH-1
- busy  out  1  set being serialised
- overflow  out  1  sticky, set when a sample set was dropped

## Operation

Reset values:
- On rst low at an edge: write_data=0, write_addr=BASE_ADDR, write_en_out=0, buf_wrap=0, busy=0, overflow=0.
- Internally: address pointer=BASE_ADDR, state IDLE, holding registers=0.

FSM with two states, IDLE and WRITE.
- IDLE -> WRITE: on sample_valid & enable. Latch all I/Q inputs and mode into holding registers and set the word index to 0.
- WRITE: emit one word per cycle.
  - Word sequence, mode 0: ch0 I, ch0 Q, ch1 I, ch1 Q, ...; W = 2*NUM_CH words.
  - Word sequence, mode 1: ch0 I, ch1 I, ...; W = NUM_CH words.
  - After word W-1: return to IDLE, unless a new set is accepted in that cycle (back-to-back).

Mode and enable:
- mode is sampled only at capture; changes mid-set have no effect on the set in flight.
- enable low blocks new captures but lets the current set finish. A strobe seen while enable is low is ignored and does not set overflow.

Address pointer:
- Increments by 1 after every word.
- After BASE_ADDR+DEPTH-1 it wraps to BASE_ADDR. buf_wrap is high in the same cycle as that word.
- The pointer persists across sets; only reset returns it to BASE_ADDR.

Overflow:
- A sample_valid & enable in WRITE while the word index is below W-1 drops the new set and sets overflow.
- clr_overflow clears the flag. If clr_overflow and a new drop occur in the same cycle, set wins.

## Timing

- Capture latency: sample_valid at edge t; first write_en_out is high during cycle t+1; the last word is in cycle t+W.
- write_data, write_addr and buf_wrap are registered and aligned with write_en_out. When write_en_out is low, write_data and write_addr hold their last values.
- busy is high in cycles t+1 .. t+W.
- Back-to-back: a strobe accepted in the cycle of word W-1 is captured at that edge. Its first word follows in the next cycle with no bubble, so write_en_out stays continuously high.
- Maximum sustained strobe rate is one per W cycles without overflow.
- Reset mid-set aborts immediately. Outputs take their reset values at that edge, the partial set is not completed, and overflow is cleared.

## Structure

- Shared package receiver_pkg holds:
  - the state enum (IDLE, WRITE);
  - the mode constants MODE_IQ=0 and MODE_I_ONLY=1;
  - a function giving words per set from NUM_CH and mode.
- One sub-module, addr_ring_counter. Parameters ADDR_W, BASE_ADDR, DEPTH; ports dsp_clk, rst, inc, addr, wrap. It holds the wrapping pointer and wrap flag.
- The top level holds the FSM, the holding registers and the word-select multiplexer.

## Test plan

- NUM_CH=1, mode 0, single strobe with I=16'h1111, Q=16'h2222 -> writes 1111@0, 2222@1 in cycles t+1 and t+2; busy high for 2 cycles.
- NUM_CH=2, mode 1, I={16'hBBBB,16'hAAAA} -> writes AAAA@n, BBBB@n+1; no Q words.
- DEPTH=4, NUM_CH=1, mode 0, three strobes spaced 3 cycles apart -> addresses 0,1,2,3,0,1; buf_wrap pulses on the write to address 3.
- NUM_CH=2, mode 0, second strobe 2 cycles after the first -> second set dropped, overflow=1, only 4 writes. clr_overflow then clears the flag.
- Strobe exactly in the last-word cycle -> continuous write_en_out for 2W cycles, no overflow. Separately, assert rst low mid-set -> write_en_out=0 and write_addr=BASE_ADDR at the next edge.
- enable low with a strobe during a set -> current set completes, strobe ignored, overflow stays 0.

Source files
------------

// File: rtl/receiver_pkg.sv
// Shared definitions for the receiver input buffer.
//   state_t       : serialiser FSM states (IDLE, WRITE)
//   MODE_IQ       : write I then Q for every channel
//   MODE_I_ONLY   : write only the I word of every channel
//   words_per_set : number of memory words produced by one captured set
package receiver_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic MODE_IQ     = 1'b0;
  localparam logic MODE_I_ONLY = 1'b1;

  function automatic int words_per_set(input int num_ch, input logic mode);
    return (mode == MODE_I_ONLY) ? num_ch : 2 * num_ch;
  endfunction

endpackage

// File: rtl/addr_ring_counter.sv
// Circular write-address generator.
// Ports:
//   dsp_clk : clock, rising edge
//   rst     : synchronous active-low reset
//   inc     : a word is written at this edge; register its address and advance
//   addr    : registered address of the word currently being written
//   wrap    : registered, high with the word written to BASE_ADDR+DEPTH-1
module addr_ring_counter #(
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              dsp_clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BASE_ADDR + DEPTH - 1);

  // ptr is the address the next word will use; addr holds the last one used
  // so the memory side sees a stable address while write_en_out is low.
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge dsp_clk) begin
    if (!rst) begin
      ptr  <= FIRST;
      addr <= FIRST;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (inc) begin
        addr <= ptr;
        wrap <= (ptr == LAST);
        ptr  <= (ptr == LAST) ? FIRST : ptr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/receiver_input_buffer.sv
// Captures NUM_CH I/Q sample pairs on a one-cycle strobe and serialises them
// into a one-word-per-cycle memory write stream over a circular buffer.
// Ports:
//   dsp_clk, rst            : clock and synchronous active-low reset
//   enable                  : allow new captures
//   mode                    : MODE_IQ or MODE_I_ONLY, sampled at capture
//   sample_valid            : one-cycle strobe qualifying the sample inputs
//   inphase_input, quad_input : packed samples, channel 0 in the LSBs
//   clr_overflow            : clears the sticky overflow flag
//   write_data, write_addr, write_en_out, buf_wrap : registered write stream
//   busy                    : a set is being written out
//   overflow                : sticky, a set was dropped
// Handshake: there is no back-pressure. A set is accepted when
// sample_valid & enable is seen while idle or while the final word of the
// current set is on the outputs; any other accepted strobe is dropped and
// flags overflow.
module receiver_input_buffer
  import receiver_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int NUM_CH    = 1,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic                     dsp_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     mode,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] inphase_input,
  input  logic [NUM_CH*DATA_W-1:0] quad_input,
  input  logic                     clr_overflow,
  output logic [DATA_W-1:0]        write_data,
  output logic [ADDR_W-1:0]        write_addr,
  output logic                     write_en_out,
  output logic                     buf_wrap,
  output logic                     busy,
  output logic                     overflow
);

  localparam int IDX_W = $clog2(2 * NUM_CH) + 1;
  localparam int SET_W = NUM_CH * DATA_W;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx, nxt_idx, last_idx;
  logic [SET_W-1:0]   hold_i, hold_q;
  logic               hold_mode;
  logic               accept, capture, emit, drop;
  logic [DATA_W-1:0]  data_nx, sel_word;

  assign accept   = sample_valid & enable;
  // idx is the index of the word currently on the outputs.
  assign last_idx = IDX_W'(words_per_set(NUM_CH, hold_mode) - 1);
  assign nxt_idx  = idx + IDX_W'(1);
  assign busy     = (state == WRITE);

  // Word nxt_idx of the held set: I-only walks channels, I/Q alternates.
  always_comb begin
    sel_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hold_mode == MODE_I_ONLY) begin
        if (nxt_idx == IDX_W'(c)) sel_word = hold_i[c*DATA_W +: DATA_W];
      end else begin
        if (nxt_idx == IDX_W'(2 * c))     sel_word = hold_i[c*DATA_W +: DATA_W];
        if (nxt_idx == IDX_W'(2 * c + 1)) sel_word = hold_q[c*DATA_W +: DATA_W];
      end
    end
  end

  // Word 0 of a fresh set is always channel 0 I in both modes, so it comes
  // straight from the inputs and is registered on the capture edge.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    capture  = 1'b0;
    emit     = 1'b0;
    drop     = 1'b0;
    data_nx  = write_data;
    case (state)
      IDLE: begin
        if (accept) begin
          capture  = 1'b1;
          emit     = 1'b1;
          idx_nx   = '0;
          data_nx  = inphase_input[DATA_W-1:0];
          state_nx = WRITE;
        end
      end
      WRITE: begin
        if (idx == last_idx) begin
          if (accept) begin
            capture = 1'b1;
            emit    = 1'b1;
            idx_nx  = '0;
            data_nx = inphase_input[DATA_W-1:0];
          end else begin
            state_nx = IDLE;
          end
        end else begin
          emit    = 1'b1;
          idx_nx  = nxt_idx;
          data_nx = sel_word;
          drop    = accept;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge dsp_clk) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      hold_i       <= '0;
      hold_q       <= '0;
      hold_mode    <= MODE_IQ;
      write_data   <= '0;
      write_en_out <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      write_data   <= data_nx;
      write_en_out <= emit;
      if (capture) begin
        hold_i    <= inphase_input;
        hold_q    <= quad_input;
        hold_mode <= mode;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  addr_ring_counter #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .DEPTH    (DEPTH)
  ) u_addr (
    .dsp_clk(dsp_clk),
    .rst    (rst),
    .inc    (emit),
    .addr   (write_addr),
    .wrap   (buf_wrap)
  );

endmodule

// File: tb/tb_receiver_input_buffer.sv
// Bench for receiver_input_buffer: NUM_CH=2, 16-bit samples, an 8-bit
// address and a 6-word ring starting at address 4.
module tb_receiver_input_buffer;
  import receiver_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int NUM_CH = 2;
  localparam int BASE   = 4;
  localparam int DEPTH  = 6;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                     enable, mode, sample_valid, clr_overflow;
  logic [NUM_CH*DATA_W-1:0] inphase_input, quad_input;
  logic [DATA_W-1:0]        write_data;
  logic [ADDR_W-1:0]        write_addr;
  logic                     write_en_out, buf_wrap, busy, overflow;

  receiver_input_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
    .BASE_ADDR(BASE), .DEPTH(DEPTH)
  ) dut (
    .dsp_clk      (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .sample_valid (sample_valid),
    .inphase_input(inphase_input),
    .quad_input   (quad_input),
    .clr_overflow (clr_overflow),
    .write_data   (write_data),
    .write_addr   (write_addr),
    .write_en_out (write_en_out),
    .buf_wrap     (buf_wrap),
    .busy         (busy),
    .overflow     (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Words still to be written live in exp_q; a new set is only taken when
  // nothing is pending beyond the word now on the outputs.
  logic [DATA_W-1:0] exp_q[$];
  int                m_ptr;
  bit                m_started = 1'b0;
  logic              m_en, m_wrap, m_ovf;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;

  always @(posedge clk) begin
    bit dropped;
    m_started = 1'b1;
    dropped   = 1'b0;
    if (!rst) begin
      exp_q.delete();
      m_ptr  = 0;
      m_en   = 1'b0;
      m_wrap = 1'b0;
      m_ovf  = 1'b0;
      m_data = '0;
      m_addr = ADDR_W'(BASE);
    end else begin
      if (sample_valid && enable) begin
        if (exp_q.size() > 0) begin
          dropped = 1'b1;
          m_ovf   = 1'b1;
        end else begin
          for (int c = 0; c < NUM_CH; c++) begin
            exp_q.push_back(inphase_input[c*DATA_W +: DATA_W]);
            if (mode == MODE_IQ) exp_q.push_back(quad_input[c*DATA_W +: DATA_W]);
          end
        end
      end
      if (!dropped && clr_overflow) m_ovf = 1'b0;
      if (exp_q.size() > 0) begin
        m_data = exp_q.pop_front();
        m_addr = ADDR_W'(BASE + m_ptr);
        m_wrap = (m_ptr == DEPTH - 1);
        m_ptr  = (m_ptr + 1) % DEPTH;
        m_en   = 1'b1;
      end else begin
        m_en   = 1'b0;
        m_wrap = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_started) begin
      check("m_en",   write_en_out, m_en);
      check("m_busy", busy,         m_en);
      check("m_ovf",  overflow,     m_ovf);
      check("m_data", write_data,   m_data);
      check("m_addr", write_addr,   m_addr);
      check("m_wrap", buf_wrap,     m_wrap);
    end
  end

  // ---------------- driver tasks ----------------
  // Present a strobe for one edge; returns in the cycle word 0 is visible.
  task automatic pulse(input logic [31:0] i, input logic [31:0] q, input logic m);
    sample_valid  = 1'b1;
    inphase_input = i;
    quad_input    = q;
    mode          = m;
    @(negedge clk);
    sample_valid  = 1'b0;
  endtask

  task automatic expect_word(input string name, input logic [15:0] d,
                             input logic [7:0] a, input logic w);
    check({name, "_en"},   write_en_out, 1);
    check({name, "_data"}, write_data,   d);
    check({name, "_addr"}, write_addr,   a);
    check({name, "_wrap"}, buf_wrap,     w);
    @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b0; enable = 1'b1; mode = MODE_IQ; sample_valid = 1'b0;
    clr_overflow = 1'b0; inphase_input = '0; quad_input = '0;
    repeat (3) @(negedge clk);
    check("rst_en",   write_en_out, 0);
    check("rst_addr", write_addr,   4);
    check("rst_data", write_data,   0);
    check("rst_busy", busy,         0);
    check("rst_ovf",  overflow,     0);
    rst = 1'b1;
    @(negedge clk);

    // I/Q mode, two channels
    pulse({16'h3333, 16'h1111}, {16'h4444, 16'h2222}, MODE_IQ);
    check("iq_busy", busy, 1);
    expect_word("iq0", 16'h1111, 8'd4, 1'b0);
    expect_word("iq1", 16'h2222, 8'd5, 1'b0);
    expect_word("iq2", 16'h3333, 8'd6, 1'b0);
    expect_word("iq3", 16'h4444, 8'd7, 1'b0);
    check("iq_done_en",   write_en_out, 0);
    check("iq_hold_addr", write_addr,   7);
    check("iq_hold_data", write_data,   16'h4444);

    // I-only mode, ends on the last ring slot
    pulse({16'hBBBB, 16'hAAAA}, {16'hEEEE, 16'hDDDD}, MODE_I_ONLY);
    expect_word("io0", 16'hAAAA, 8'd8, 1'b0);
    expect_word("io1", 16'hBBBB, 8'd9, 1'b1);
    check("io_done_en",   write_en_out, 0);
    check("io_done_wrap", buf_wrap,     0);

    // second strobe two cycles in: dropped
    pulse({16'h0202, 16'h0101}, {16'h0404, 16'h0303}, MODE_IQ);
    @(negedge clk);
    pulse({16'h0909, 16'h0808}, {16'h0B0B, 16'h0A0A}, MODE_IQ);
    check("ovf_set", overflow, 1);
    expect_word("ov2", 16'h0202, 8'd6, 1'b0);
    expect_word("ov3", 16'h0404, 8'd7, 1'b0);
    check("ov_only4",   write_en_out, 0);
    check("ovf_sticky", overflow,     1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_clr", overflow, 0);

    // drop and clear in the same cycle: set wins
    pulse({16'h5252, 16'h5151}, '0, MODE_I_ONLY);
    clr_overflow = 1'b1;
    pulse({16'h5454, 16'h5353}, '0, MODE_I_ONLY);
    clr_overflow = 1'b0;
    check("set_wins", overflow, 1);
    check("sw_wrap",  buf_wrap, 1);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("sw_clr", overflow, 0);

    // back-to-back: strobe in the last-word cycle, no bubble
    pulse({16'hA2A2, 16'hA1A1}, {16'hA4A4, 16'hA3A3}, MODE_IQ);
    for (int k = 0; k < 3; k++) begin
      check("b2b_en", write_en_out, 1);
      @(negedge clk);
    end
    check("b2b_en", write_en_out, 1);
    pulse({16'hB2B2, 16'hB1B1}, '0, MODE_I_ONLY);
    expect_word("b2b_b0", 16'hB1B1, 8'd8, 1'b0);
    expect_word("b2b_b1", 16'hB2B2, 8'd9, 1'b1);
    check("b2b_end", write_en_out, 0);
    check("b2b_ovf", overflow,     0);

    // enable low: set finishes, strobes ignored, mode change has no effect
    pulse({16'hC1C1, 16'hC0C0}, {16'hD1D1, 16'hD0D0}, MODE_IQ);
    enable = 1'b0;
    pulse({16'hEEEE, 16'hEEEE}, {16'hEEEE, 16'hEEEE}, MODE_I_ONLY);
    check("en_ovf", overflow, 0);
    @(negedge clk);
    check("en_w2", write_data, 16'hC1C1);
    @(negedge clk);
    check("en_w3", write_data, 16'hD1D1);
    check("en_a3", write_addr, 7);
    pulse({16'hEEEE, 16'hEEEE}, '0, MODE_I_ONLY);
    check("en_idle", write_en_out, 0);
    check("en_busy", busy,         0);
    check("en_ovf2", overflow,     0);
    enable = 1'b1;
    mode   = MODE_IQ;

    // reset mid-set
    pulse({16'hE2E2, 16'hE1E1}, {16'hE4E4, 16'hE3E3}, MODE_IQ);
    check("mr_a0", write_addr, 8);
    pulse({16'hF2F2, 16'hF1F1}, '0, MODE_IQ);
    check("mr_a1",  write_addr, 9);
    check("mr_ovf", overflow,   1);
    rst = 1'b0;
    @(negedge clk);
    check("mr_en",   write_en_out, 0);
    check("mr_addr", write_addr,   4);
    check("mr_data", write_data,   0);
    check("mr_busy", busy,         0);
    check("mr_ovf0", overflow,     0);
    rst = 1'b1;
    @(negedge clk);
    check("mr_abort", write_en_out, 0);
    pulse({16'h6262, 16'h6161}, '0, MODE_I_ONLY);
    expect_word("mr_g0", 16'h6161, 8'd4, 1'b0);
    expect_word("mr_g1", 16'h6262, 8'd5, 1'b0);
    check("mr_g_end", write_en_out, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
